// File: rtl/demux1to8_framer_if.sv
// Interface bundling the sample stream, the frame outputs and the status
// signals of demux1to8_framer.
//   slave  : seen by the framer (takes the input stream, drives the frame bank)
//   master : seen by the environment (drives the input stream, takes frames)
interface demux1to8_framer_if #(
  parameter int unsigned DW = 1
) ();

  // Input sample stream
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          in_ready;

  // Demultiplexed frame bank
  logic [DW-1:0] out0;
  logic [DW-1:0] out1;
  logic [DW-1:0] out2;
  logic [DW-1:0] out3;
  logic [DW-1:0] out4;
  logic [DW-1:0] out5;
  logic [DW-1:0] out6;
  logic [DW-1:0] out7;
  logic          out_valid;
  logic          out_ready;

  // Status
  logic [2:0]    sel_cur;
  logic          frame_err;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sof,
    output in_ready,
    output out0,
    output out1,
    output out2,
    output out3,
    output out4,
    output out5,
    output out6,
    output out7,
    output out_valid,
    input  out_ready,
    output sel_cur,
    output frame_err
  );

  modport master (
    output in_valid,
    output in_data,
    output in_sof,
    input  in_ready,
    input  out0,
    input  out1,
    input  out2,
    input  out3,
    input  out4,
    input  out5,
    input  out6,
    input  out7,
    input  out_valid,
    output out_ready,
    input  sel_cur,
    input  frame_err
  );

endinterface

// File: rtl/demux1to8_framer.sv
// 1-to-8 demultiplexing framer.
// Collects a serial stream of DW-bit samples into an 8-entry shadow bank,
// channel 0 marked by in_sof, and hands each complete frame to a
// double-buffered output bank (out0..out7 / out_valid / out_ready).
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus_if  : demux1to8_framer_if.slave
//             in_valid/in_data/in_sof/in_ready : sample stream
//             out0..out7/out_valid/out_ready   : frame output bank
//             sel_cur                          : next channel to be written
//             frame_err                        : one-cycle framing error pulse
module demux1to8_framer #(
  parameter int unsigned DW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1to8_framer_if.slave     bus_if
);

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [DW-1:0] shadow_q [NCH];
  logic [DW-1:0] shadow_d [NCH];
  logic [DW-1:0] obank_q  [NCH];
  logic [DW-1:0] obank_d  [NCH];
  logic          out_valid_q, out_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          in_ready_q,  in_ready_d;

  logic          accept_c;
  logic          bank_free_c;
  logic          last_c;

  // Beat handshake and output-bank availability for this edge
  assign accept_c    = bus_if.in_valid && in_ready_q;
  assign bank_free_c = !out_valid_q || bus_if.out_ready;
  assign last_c      = (cnt_q == CW'(NCH - 1));

  // State and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      in_ready_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        obank_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      in_ready_q  <= in_ready_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        obank_q[i]  <= obank_d[i];
      end
    end
  end

  // Next-state, collection and transfer logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      obank_d[i]  = obank_q[i];
    end
    // A consumed frame drops out_valid unless a transfer below refills it
    out_valid_d = out_valid_q && !bus_if.out_ready;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bus_if.in_sof) begin
            shadow_d[0] = bus_if.in_data;
            cnt_d       = CW'(1);
            state_d     = S_COLLECT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (accept_c) begin
          if (bus_if.in_sof) begin
            // Restart: the partial frame is abandoned, this beat is channel 0
            frame_err_d = 1'b1;
            shadow_d[0] = bus_if.in_data;
            cnt_d       = CW'(1);
          end else begin
            shadow_d[cnt_q] = bus_if.in_data;
            cnt_d           = cnt_q + CW'(1);
            if (last_c) begin
              if (bank_free_c) begin
                // Channel 7 bypasses the shadow bank for single-cycle latency
                for (int i = 0; i < NCH - 1; i++) begin
                  obank_d[i] = shadow_q[i];
                end
                obank_d[NCH-1] = bus_if.in_data;
                out_valid_d    = 1'b1;
                state_d        = S_IDLE;
              end else begin
                state_d = S_FULL;
              end
            end
          end
        end
      end

      S_FULL: begin
        // out_valid is necessarily 1 here, so out_ready means consumption
        if (bus_if.out_ready) begin
          for (int i = 0; i < NCH; i++) begin
            obank_d[i] = shadow_q[i];
          end
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered ready follows the state the block is about to enter
    in_ready_d = (state_d != S_FULL);
  end

  assign bus_if.in_ready  = in_ready_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.frame_err = frame_err_q;
  assign bus_if.sel_cur   = cnt_q;
  assign bus_if.out0      = obank_q[0];
  assign bus_if.out1      = obank_q[1];
  assign bus_if.out2      = obank_q[2];
  assign bus_if.out3      = obank_q[3];
  assign bus_if.out4      = obank_q[4];
  assign bus_if.out5      = obank_q[5];
  assign bus_if.out6      = obank_q[6];
  assign bus_if.out7      = obank_q[7];

endmodule

// File: tb/tb_demux1to8_framer.sv
// Self-checking bench for demux1to8_framer (DW=4).
module tb_demux1to8_framer;

  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux1to8_framer_if #(.DW(DW)) ifc ();

  demux1to8_framer #(.DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (ifc)
  );

  int total   = 0;
  int bad     = 0;
  int err_cnt = 0;
  int cyc     = 0;

  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] obs_frame;
  logic        pv = 1'b0;
  logic        pr = 1'b0;

  assign obs_frame = {ifc.out7, ifc.out6, ifc.out5, ifc.out4,
                      ifc.out3, ifc.out2, ifc.out1, ifc.out0};

  always @(posedge clk) cyc++;

  // Capture every newly presented frame and count frame_err pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (ifc.out_valid && (!pv || pr)) got_q.push_back(obs_frame);
      if (ifc.frame_err) err_cnt++;
      pv = ifc.out_valid;
      pr = ifc.out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Present one beat and hold it until accepted; returns at posedge+1
  task automatic drive_beat(input logic [DW-1:0] d, input logic s);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_sof   = s;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    ifc.in_valid = 1'b0;
    ifc.in_data  = DW'($urandom_range(0, 15));
    ifc.in_sof   = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout data=%h", d);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_sof    = 1'b0;
    ifc.out_ready = 1'b1;
    #2;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", ifc.in_ready); end
    total++; if (ifc.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", ifc.frame_err); end
    total++; if (ifc.sel_cur !== 3'd0) begin bad++; $display("FAIL reset_sel_cur got=%0d exp=0", ifc.sel_cur); end
    total++; if (obs_frame !== 32'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs_frame); end
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", ifc.in_ready); end
  endtask

  task automatic test_single_frame();
    int          n;
    logic [31:0] e, g;
    ifc.out_ready = 1'b1;
    exp_q.push_back(32'h87654321);
    for (int i = 0; i < 8; i++) begin
      drive_beat(DW'(i + 1), (i == 0));
      total++;
      if (ifc.sel_cur !== 3'(i + 1)) begin
        bad++; $display("FAIL single_sel_cur beat=%0d got=%0d exp=%0d", i, ifc.sel_cur, 3'(i + 1));
      end
    end
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL single_latency out_valid got=%b exp=1", ifc.out_valid); end
    total++; if (obs_frame !== 32'h87654321) begin bad++; $display("FAIL single_frame got=%h exp=87654321", obs_frame); end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL single_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL single_sb_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL single_extra_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_backpressure();
    int          n;
    logic [31:0] e, g;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    exp_q.push_back(32'h87654321);
    exp_q.push_back(32'h0FEDCBA9);
    for (int i = 0; i < 16; i++) drive_beat(DW'(i + 1), (i == 0) || (i == 8));
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%b exp=0", ifc.in_ready); end
    total++; if (obs_frame !== 32'h87654321) begin bad++; $display("FAIL bp_hold_a got=%h exp=87654321", obs_frame); end
    repeat (3) begin @(posedge clk); #1; end
    total++; if (obs_frame !== 32'h87654321 || ifc.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stable_a got=%h/%b exp=87654321/1", obs_frame, ifc.out_valid);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (obs_frame !== 32'h0FEDCBA9 || ifc.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_transfer_b got=%h/%b exp=0fedcba9/1", obs_frame, ifc.out_valid);
    end
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back got=%b exp=1", ifc.in_ready); end
    @(posedge clk); #1;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b exp=0", ifc.out_valid); end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL bp_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL bp_sb_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL bp_extra_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_no_sof();
    int e0;
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    e0 = err_cnt;
    drive_beat(4'h5, 1'b0);
    drive_beat(4'h6, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    total++; if (err_cnt - e0 !== 2) begin bad++; $display("FAIL nosof_err_pulses got=%0d exp=2", err_cnt - e0); end
    total++; if (ifc.sel_cur !== 3'd0) begin bad++; $display("FAIL nosof_sel_cur got=%0d exp=0", ifc.sel_cur); end
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL nosof_out_valid got=%b exp=0", ifc.out_valid); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL nosof_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_restart();
    int          n, e0;
    logic [31:0] e, g;
    logic [3:0]  v [8];
    @(posedge clk); #1;
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) v[i] = 4'(4'hA + i);
    e = '0;
    for (int i = 0; i < 8; i++) e[4*i +: 4] = v[i];
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) drive_beat(DW'(i + 1), (i == 0));
    for (int i = 0; i < 8; i++) drive_beat(v[i], (i == 0));
    repeat (2) begin @(posedge clk); #1; end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL restart_err_pulses got=%0d exp=1", err_cnt - e0); end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL restart_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL restart_sb_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL restart_extra_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_gaps();
    int          n;
    logic [31:0] e, g;
    logic [3:0]  v [8];
    logic [2:0]  sc;
    @(posedge clk); #1;
    e = '0;
    for (int i = 0; i < 8; i++) begin v[i] = 4'($urandom_range(0, 15)); e[4*i +: 4] = v[i]; end
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      drive_beat(v[i], (i == 0));
      sc = ifc.sel_cur;
      // Idle cycles with junk data and sof must leave state untouched
      repeat (2) begin
        ifc.in_data = 4'($urandom_range(0, 15));
        ifc.in_sof  = 1'b1;
        @(posedge clk); #1;
      end
      ifc.in_sof = 1'b0;
      if (i < 7) begin
        total++; if (ifc.sel_cur !== sc) begin bad++; $display("FAIL gap_sel_cur got=%0d exp=%0d", ifc.sel_cur, sc); end
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL gap_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL gap_sb_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL gap_extra_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int          n, c0;
    logic [31:0] e, g;
    logic [3:0]  v [32];
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      e = '0;
      for (int i = 0; i < 8; i++) begin
        v[8*f + i] = 4'($urandom_range(0, 15));
        e[4*i +: 4] = v[8*f + i];
      end
      exp_q.push_back(e);
    end
    c0 = cyc;
    for (int k = 0; k < 32; k++) drive_beat(v[k], (k % 8) == 0);
    total++; if (cyc - c0 !== 32) begin bad++; $display("FAIL b2b_throughput got=%0d exp=32", cyc - c0); end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL b2b_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL b2b_sb_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL b2b_extra_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_in_full();
    int          n, e0;
    logic [31:0] e, g;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    exp_q.push_back(32'h87654321);
    // Frame A is presented; frame B parks in FULL and must never appear
    for (int i = 0; i < 16; i++) drive_beat(DW'(i + 1), (i == 0) || (i == 8));
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL rstfull_in_full got=%b exp=0", ifc.in_ready); end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL rstfull_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL rstfull_sb_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_out_valid got=%b exp=0", ifc.out_valid); end
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL rstfull_in_ready got=%b exp=0", ifc.in_ready); end
    total++; if (obs_frame !== 32'h0) begin bad++; $display("FAIL rstfull_outputs got=%h exp=0", obs_frame); end
    total++; if (ifc.sel_cur !== 3'd0) begin bad++; $display("FAIL rstfull_sel_cur got=%0d exp=0", ifc.sel_cur); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_stale_valid got=%b exp=0", ifc.out_valid); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstfull_stale_frame got=%0d exp=0", got_q.size()); got_q.delete(); end
    // After release a beat without sof is a framing error
    e0 = err_cnt;
    drive_beat(4'h3, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL rstfull_need_sof got=%0d exp=1", err_cnt - e0); end
    exp_q.push_back(32'h21436587);
    drive_beat(4'h7, 1'b1); drive_beat(4'h8, 1'b0); drive_beat(4'h5, 1'b0); drive_beat(4'h6, 1'b0);
    drive_beat(4'h3, 1'b0); drive_beat(4'h4, 1'b0); drive_beat(4'h1, 1'b0); drive_beat(4'h2, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (got_q.size() != 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL rstfull_post_sb got=%h exp=%h", g, e); end
      end else begin @(negedge clk); n++; end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL rstfull_post_timeout pending=%0d", exp_q.size()); exp_q.delete(); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstfull_extra_frames got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_no_sof();
    test_restart();
    test_gaps();
    test_back_to_back();
    test_reset_in_full();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1to8_framer.md
DEMUX1TO8_FRAMER -- requirements
Module: demux1to8_framer

Interface
REQ-001 Parameter: DW, default 1, bit width of each channel sample.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  input sample present.
REQ-005 in_data  input  DW  input sample.
REQ-006 in_sof  input  1  start-of-frame marker; the sample carrying it is channel 0. Qualified by in_valid.
REQ-007 in_ready  output  1  block accepts a sample; a beat is accepted when in_valid && in_ready at the clock edge.
REQ-008 out0..out7  output  DW each  demultiplexed frame; outN holds the channel-N sample.
REQ-009 out_valid  output  1  out0..out7 hold a complete frame.
REQ-010 out_ready  input  1  consumer takes the frame; a frame is consumed when out_valid && out_ready at the clock edge.
REQ-011 sel_cur  output  3  index of the channel the next accepted beat is written to (the collection counter).
REQ-012 frame_err  output  1  one-cycle pulse on a framing error.

Function
REQ-013 Internal storage SHALL be a shadow bank of 8 x DW registers, the output bank (out0..out7), and a 3-bit counter cnt (sel_cur = cnt).
REQ-014 The FSM SHALL have three states:
- IDLE: awaiting start of frame.
- COLLECT: filling the shadow bank.
- FULL: shadow bank complete, awaiting a free output bank.
REQ-015 in_ready SHALL be 1 in IDLE and COLLECT, and 0 in FULL and while rst_n is low.
REQ-016 IDLE, accepted beat with in_sof=1: write shadow[0], set cnt=1, go to COLLECT.
REQ-017 IDLE, accepted beat with in_sof=0: discard the beat, pulse frame_err, keep cnt=0, stay in IDLE.
REQ-018 COLLECT, accepted beat with in_sof=0: write shadow[cnt], then cnt=cnt+1 (3-bit, wraps 7 to 0).
REQ-019 COLLECT, accepted beat with in_sof=1: pulse frame_err, discard the partial frame, write shadow[0], set cnt=1, stay in COLLECT.
REQ-020 On acceptance of the channel-7 beat (cnt=7, in_sof=0):
- If the output bank is free (out_valid=0, or out_ready=1 on that same edge): copy shadow[0..6] and the new beat to out0..out7, set out_valid=1, set cnt=0, go to IDLE.
- Otherwise: go to FULL with cnt=0.
REQ-021 FULL, on an edge with out_ready=1: copy the shadow bank to out0..out7, keep out_valid=1, go to IDLE.
REQ-022 Output-bank consumption with no transfer on the same edge SHALL clear out_valid to 0.
REQ-023 out0..out7 SHALL change only on a transfer, and SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Latency: out_valid SHALL be 1 in the cycle immediately after the edge that accepts channel 7, when the output bank is free.
REQ-025 Full throughput: one beat per cycle SHALL be sustained indefinitely while out_ready=1.
REQ-026 frame_err SHALL be registered, high for exactly one cycle per error event, and SHALL not stall in_ready.
REQ-027 Beats with in_valid=0 SHALL change no state.
REQ-028 in_data SHALL be ignored when not accepted.

Reset
REQ-029 While rst_n=0, independent of clk, the block SHALL hold: state=IDLE, cnt=0, out0..out7=0, out_valid=0, frame_err=0, in_ready=0, shadow bank=0.
REQ-030 Reset asserted mid-frame, or in FULL, SHALL discard all partial and pending data; no frame SHALL be emitted for it after release.
REQ-031 After rst_n rises, the first accepted beat SHALL require in_sof=1 to start a frame.

Verification
REQ-032 DW=4, out_ready=1, back-to-back frame 0x1..0x8 with in_sof on the first beat. Required: out0..out7 = 1..8, out_valid high in the cycle after beat 8, sel_cur steps 1..7 then 0.
REQ-033 out_ready=0, two consecutive frames (A = 0x1..0x8, B = 0x9..0x0). Required:
- in_ready drops after B channel 7.
- Outputs hold A until out_ready=1.
- On that edge, out0..out7 become B and out_valid stays 1.
- The next edge with out_ready=1 clears out_valid.
REQ-034 Beats 0x5,0x6 with in_sof=0 from IDLE. Required: two frame_err pulses, no frame emitted, sel_cur=0.
REQ-035 Frame restart: in_sof reasserted at channel 4, then 8 clean beats 0xA..0x1. Required: one frame_err pulse, emitted frame = 0xA..0x1.
REQ-036 rst_n pulsed low for 1 ns between edges while in FULL. Required:
- Immediate outputs=0, out_valid=0, in_ready=0.
- After release: IDLE, no stale frame ever appears.
